mem_stage: RTL

//  Memory-access stage directly downstream of the ALU stage. Takes the ALU result (address or value),

---
 rtl/mem_stage.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// Memory-access stage: word/byte load/store over a req/ack data port,
// stalls upstream while an access is outstanding, registers results to writeback.
module mem_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [4:0]  in_regD,
    input  logic        in_reg_write,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        mem_byte,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_regD,
    output logic        wb_reg_write,
    output logic        mem_error
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_cnt;
    logic        r_load;
    logic        r_byte;
    logic        r_rw;
    logic [1:0]  r_lane;
    logic [4:0]  r_regD;

    logic        w_is_mem;
    logic        w_misalign;
    logic        w_accept;
    logic        w_last;
    logic [7:0]  w_rbyte;

    assign w_is_mem   = in_valid & (mem_read | mem_write);
    assign w_misalign = w_is_mem & ~mem_byte & (alu_result[1:0] != 2'b00);
    assign w_accept   = w_is_mem & ~w_misalign;
    assign w_last     = (r_cnt == CNT_LAST);
    assign w_rbyte    = mem_rdata[{r_lane, 3'b000} +: 8];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_accept) w_next = S_WAIT;
            S_WAIT: if (mem_ack || w_last) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Ack in the final timeout cycle still releases the stall as a normal completion.
    always_comb begin
        stall = 1'b0;
        unique case (r_state)
            S_IDLE: stall = w_accept;
            S_WAIT: stall = ~(mem_ack | w_last);
            default: stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_be       <= '0;
            wb_valid     <= 1'b0;
            wb_data      <= '0;
            wb_regD      <= '0;
            wb_reg_write <= 1'b0;
            mem_error    <= 1'b0;
            r_cnt        <= '0;
            r_load       <= 1'b0;
            r_byte       <= 1'b0;
            r_rw         <= 1'b0;
            r_lane       <= '0;
            r_regD       <= '0;
        end else begin
            wb_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid && !w_is_mem) begin
                        wb_valid     <= 1'b1;
                        wb_data      <= alu_result;
                        wb_regD      <= in_regD;
                        wb_reg_write <= in_reg_write;
                    end else if (w_misalign) begin
                        mem_error    <= 1'b1;
                        wb_valid     <= 1'b1;
                        wb_reg_write <= 1'b0;
                    end else if (w_accept) begin
                        mem_req  <= 1'b1;
                        mem_we   <= ~mem_read;
                        mem_addr <= {alu_result[31:2], 2'b00};
                        r_cnt    <= '0;
                        r_load   <= mem_read;
                        r_byte   <= mem_byte;
                        r_rw     <= in_reg_write;
                        r_lane   <= alu_result[1:0];
                        r_regD   <= in_regD;
                        if (mem_byte) begin
                            mem_be    <= 4'b0001 << alu_result[1:0];
                            mem_wdata <= {4{store_data[7:0]}};
                        end else begin
                            mem_be    <= 4'b1111;
                            mem_wdata <= store_data;
                        end
                    end
                end
                S_WAIT: begin
                    if (mem_ack) begin
                        mem_req      <= 1'b0;
                        wb_valid     <= 1'b1;
                        wb_regD      <= r_regD;
                        wb_reg_write <= r_load & r_rw;
                        if (!r_load) begin
                            wb_data <= '0;
                        end else if (r_byte) begin
                            wb_data <= {24'b0, w_rbyte};
                        end else begin
                            wb_data <= mem_rdata;
                        end
                    end else if (w_last) begin
                        mem_req      <= 1'b0;
                        mem_error    <= 1'b1;
                        wb_valid     <= 1'b1;
                        wb_reg_write <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
